// File: rtl/preddr_capture_sequencer.sv
`default_nettype none
// ==== preddr_capture_sequencer: trigger-armed capture with decimation, nibble packing and
// ==== optional 64-bit word padding (PREDDR_CAPTURE_PAD_EN). Rev 1.0
module preddr_capture_sequencer (
  input  logic        wr_clk,
  input  logic        reset,
  input  logic        I_enabled,
  input  logic        I_arm,
  input  logic        I_abort,
  input  logic        I_trigger,
  input  logic [17:0] I_data_in,
  input  logic        I_data_valid,
  input  logic        I_4bit_mode,
  input  logic [15:0] I_decimate,
  input  logic [31:0] I_max_samples,
  output logic [17:0] O_data,
  output logic        O_wr,
  output logic        O_capture_start,
  output logic        O_capture_done,
  output logic        O_armed,
  output logic        O_capturing
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
`ifdef PREDDR_CAPTURE_PAD_EN
    PAD     = 3'd3,
`endif
    DONE    = 3'd4
  } state_t;

`ifdef PREDDR_CAPTURE_PAD_EN
  localparam state_t END_STATE     = PAD;
  localparam logic   END_CAPTURING = 1'b1;
`else
  localparam state_t END_STATE     = DONE;
  localparam logic   END_CAPTURING = 1'b0;
`endif

  state_t      state;
  logic        trig_prev;
  logic        mode4;
  logic        half;
  logic [3:0]  nib;
  logic [15:0] dec_n;
  logic [15:0] dec_cnt;
  logic [31:0] max_lat;
  logic [31:0] kept_cnt;

  logic        trig_edge;
  logic [31:0] kept_next;
  logic        last_keep;
  logic        dec_wrap;

  assign trig_edge = I_trigger && !trig_prev;
  assign kept_next = kept_cnt + 32'd1;
  assign last_keep = (kept_next == max_lat);
  assign dec_wrap  = (dec_cnt == dec_n - 16'd1);

`ifdef PREDDR_CAPTURE_PAD_EN
  // Counts writes already on the output; the one presented this cycle is added in.
  logic [4:0] wr_cnt;
  logic [4:0] wr_total;
  logic       pad_aligned;

  always_ff @(posedge wr_clk) begin
    if (reset || state == ARMED) wr_cnt <= 5'd0;
    else if (O_wr)               wr_cnt <= wr_cnt + 5'd1;
  end

  assign wr_total    = wr_cnt + {4'd0, O_wr};
  assign pad_aligned = mode4 ? (wr_total[2:0] == 3'd0) : (wr_total == 5'd0);
`endif

  always_ff @(posedge wr_clk) begin
    O_wr            <= 1'b0;
    O_capture_start <= 1'b0;
    O_capture_done  <= 1'b0;
    trig_prev       <= I_trigger;
    if (reset || !I_enabled) begin
      state       <= IDLE;
      trig_prev   <= 1'b0;
      O_data      <= 18'd0;
      O_armed     <= 1'b0;
      O_capturing <= 1'b0;
      mode4       <= 1'b0;
      half        <= 1'b0;
      nib         <= 4'd0;
      dec_n       <= 16'd1;
      dec_cnt     <= 16'd0;
      max_lat     <= 32'd0;
      kept_cnt    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (I_arm) begin
            state   <= ARMED;
            O_armed <= 1'b1;
          end
        end
        ARMED: begin
          if (I_abort) begin
            state   <= IDLE;
            O_armed <= 1'b0;
          end else if (trig_edge) begin
            O_armed         <= 1'b0;
            O_capture_start <= 1'b1;
            max_lat         <= I_max_samples;
            dec_n           <= (I_decimate == 16'd0) ? 16'd1 : I_decimate;
            mode4           <= I_4bit_mode;
            dec_cnt         <= 16'd0;
            kept_cnt        <= 32'd0;
            half            <= 1'b0;
            if (I_max_samples == 32'd0) begin
              state       <= END_STATE;
              O_capturing <= END_CAPTURING;
            end else begin
              state       <= CAPTURE;
              O_capturing <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (I_abort) begin
            state       <= IDLE;
            O_capturing <= 1'b0;
          end else if (I_data_valid) begin
            dec_cnt <= dec_wrap ? 16'd0 : dec_cnt + 16'd1;
            if (dec_cnt == 16'd0) begin
              kept_cnt <= kept_next;
              if (!mode4) begin
                O_data <= I_data_in;
                O_wr   <= 1'b1;
              end else if (half) begin
                O_data <= {10'd0, nib, I_data_in[3:0]};
                O_wr   <= 1'b1;
                half   <= 1'b0;
              end else if (last_keep) begin
                // Odd final nibble goes out alone with a zero low nibble.
                O_data <= {10'd0, I_data_in[3:0], 4'd0};
                O_wr   <= 1'b1;
              end else begin
                nib  <= I_data_in[3:0];
                half <= 1'b1;
              end
              if (last_keep) begin
                state       <= END_STATE;
                O_capturing <= END_CAPTURING;
              end
            end
          end
        end
`ifdef PREDDR_CAPTURE_PAD_EN
        PAD: begin
          if (I_abort) begin
            state       <= IDLE;
            O_capturing <= 1'b0;
          end else if (pad_aligned) begin
            state       <= DONE;
            O_capturing <= 1'b0;
          end else begin
            O_data <= 18'd0;
            O_wr   <= 1'b1;
          end
        end
`endif
        DONE: begin
          O_capture_done <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_preddr_capture_sequencer.sv
`default_nettype none
// Bench for preddr_capture_sequencer: expected start/write/done events are queued by a
// sample-stream reference model and consumed by an output monitor.
module tb_preddr_capture_sequencer;

  localparam int EV_START = 0;
  localparam int EV_WR    = 1;
  localparam int EV_DONE  = 2;

  logic        wr_clk = 1'b0;
  logic        reset;
  logic        I_enabled, I_arm, I_abort, I_trigger, I_data_valid, I_4bit_mode;
  logic [17:0] I_data_in;
  logic [15:0] I_decimate;
  logic [31:0] I_max_samples;
  logic [17:0] O_data;
  logic        O_wr, O_capture_start, O_capture_done, O_armed, O_capturing;

  preddr_capture_sequencer dut (
    .wr_clk          (wr_clk),
    .reset           (reset),
    .I_enabled       (I_enabled),
    .I_arm           (I_arm),
    .I_abort         (I_abort),
    .I_trigger       (I_trigger),
    .I_data_in       (I_data_in),
    .I_data_valid    (I_data_valid),
    .I_4bit_mode     (I_4bit_mode),
    .I_decimate      (I_decimate),
    .I_max_samples   (I_max_samples),
    .O_data          (O_data),
    .O_wr            (O_wr),
    .O_capture_start (O_capture_start),
    .O_capture_done  (O_capture_done),
    .O_armed         (O_armed),
    .O_capturing     (O_capturing)
  );

  always #5 wr_clk = ~wr_clk;

  int cyc = 0;
  always @(posedge wr_clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [17:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  n_start = 0, n_wr = 0, n_done = 0;
  int  start_cyc = -1, first_wr_cyc = -1, last_wr_cyc = -1, done_cyc = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push_ev(input int k, input logic [17:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input logic [17:0] d, input string nm);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got unexpected event kind %0d data 0x%0h at cycle %0d, required none",
               nm, k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d) begin
        fails++;
        $display("FAIL %s: got kind %0d data 0x%0h at cycle %0d, required kind %0d data 0x%0h",
                 nm, k, d, cyc, e.kind, e.data);
      end
    end
  endtask

  // Output monitor
  always @(negedge wr_clk) begin
    if (O_capture_start) begin
      n_start++;
      start_cyc    = cyc;
      first_wr_cyc = -1;
      check("start_wr_exclusive", {31'd0, O_wr}, 32'd0);
      pop_cmp(EV_START, 18'd0, "start_event");
    end
    if (O_wr) begin
      n_wr++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      pop_cmp(EV_WR, O_data, "write_event");
    end
    if (O_capture_done) begin
      n_done++;
      done_cyc = cyc;
      pop_cmp(EV_DONE, 18'd0, "done_event");
    end
  end

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic arm();
    I_arm = 1'b1;
    step();
    I_arm = 1'b0;
  endtask

  // Drives trigger and a sample stream; the model follows the capture rules on the stream.
  task automatic capture(input int maxs, input int dec, input bit m4, input int vpct,
                         input bit seq, input int base, input int abort_at, output int t_trig);
    int          n, vcnt, kept, writes, idx;
    bit          half, aborted, v;
    logic [3:0]  nib;
    logic [17:0] d;
    n = (dec == 0) ? 1 : dec;
    vcnt = 0; kept = 0; writes = 0; idx = 0;
    half = 1'b0; aborted = 1'b0; nib = 4'd0;
    I_max_samples = maxs;
    I_decimate    = dec[15:0];
    I_4bit_mode   = m4;
    I_trigger     = 1'b1;
    t_trig        = cyc;
    push_ev(EV_START, 18'd0);
    step();
    I_max_samples = $urandom;
    I_decimate    = 16'($urandom);
    while (kept < maxs && idx < 4000) begin
      I_arm = (idx == 1);
      if (idx == abort_at) begin
        I_abort      = 1'b1;
        I_data_valid = 1'b1;
        I_data_in    = 18'($urandom);
        step();
        I_abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      v = seq ? 1'b1 : (int'($urandom_range(99)) < vpct);
      d = seq ? 18'(base + idx) : 18'($urandom);
      I_data_valid = v;
      I_data_in    = d;
      if (v) begin
        if (vcnt % n == 0) begin
          kept++;
          if (!m4) begin
            push_ev(EV_WR, d);
            writes++;
          end else if (half) begin
            push_ev(EV_WR, {10'd0, nib, d[3:0]});
            half = 1'b0;
            writes++;
          end else if (kept == maxs) begin
            push_ev(EV_WR, {10'd0, d[3:0], 4'd0});
            writes++;
          end else begin
            nib  = d[3:0];
            half = 1'b1;
          end
        end
        vcnt++;
      end
      step();
      idx++;
    end
    I_arm = 1'b0;
    if (!aborted) begin
`ifdef PREDDR_CAPTURE_PAD_EN
      while (writes % (m4 ? 8 : 32) != 0) begin
        push_ev(EV_WR, 18'd0);
        writes++;
      end
`endif
      push_ev(EV_DONE, 18'd0);
    end
    repeat (3) begin
      I_data_valid = 1'($urandom);
      I_data_in    = 18'($urandom);
      step();
    end
    I_data_valid = 1'b0;
    I_trigger    = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 300 && n_done == d0; i++) step();
    check("done_pulse_count", n_done - d0, 32'd1);
    step();
    check("idle_after_done", {30'd0, O_armed, O_capturing}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, d0, s0;
    reset = 1'b1; I_enabled = 1'b1; I_arm = 1'b0; I_abort = 1'b0; I_trigger = 1'b0;
    I_data_valid = 1'b0; I_data_in = 18'd0; I_4bit_mode = 1'b0; I_decimate = 16'd1;
    I_max_samples = 32'd0;
    repeat (2) step();
    check("reset_outputs", {9'd0, O_data, O_wr, O_capture_start, O_capture_done, O_armed,
                            O_capturing}, 32'd0);
    reset = 1'b0;
    step();

    // Basic timing: decimate 1, max 5, valid every cycle
    arm();
    check("armed_after_arm", {31'd0, O_armed}, 32'd1);
    d0 = n_done;
    capture(5, 1, 1'b0, 100, 1'b1, 0, -1, t);
    wait_done(d0);
    check("start_at_T+1", start_cyc - t, 32'd1);
    check("first_wr_at_T+2", first_wr_cyc - t, 32'd2);
    check("done_after_last_wr", {31'd0, done_cyc > last_wr_cyc}, 32'd1);
`ifndef PREDDR_CAPTURE_PAD_EN
    check("last_wr_at_T+6", last_wr_cyc - t, 32'd6);
    check("done_at_T+7", done_cyc - t, 32'd7);
`endif

    // Decimate 3 over 0..8, max 3 -> 0,3,6
    arm(); d0 = n_done;
    capture(3, 3, 1'b0, 100, 1'b1, 0, -1, t);
    wait_done(d0);

    // 4-bit packing of A,B,C -> 0x0AB, 0x0C0
    arm(); d0 = n_done;
    capture(3, 1, 1'b1, 100, 1'b1, 10, -1, t);
    wait_done(d0);

    // Zero max samples: start and done only
    arm(); d0 = n_done;
    capture(0, 1, 1'b0, 100, 1'b0, 0, -1, t);
    wait_done(d0);

    // Trigger already high at arm needs a fresh rising edge
    I_trigger = 1'b1; step();
    s0 = n_start;
    arm();
    repeat (4) step();
    check("no_start_on_held_trigger", n_start - s0, 32'd0);
    check("still_armed", {31'd0, O_armed}, 32'd1);
    I_trigger = 1'b0; step();
    d0 = n_done;
    capture(4, 2, 1'b0, 70, 1'b0, 0, -1, t);
    wait_done(d0);

    // Abort mid-capture: no done pulse
    arm(); d0 = n_done;
    capture(20, 1, 1'b0, 100, 1'b1, 50, 4, t);
    repeat (10) step();
    check("abort_no_done", n_done - d0, 32'd0);
    check("abort_idle", {30'd0, O_armed, O_capturing}, 32'd0);
    check("abort_drained", exp_q.size(), 32'd0);

    // Reset while the third write is on the outputs
    arm(); d0 = n_done;
    I_max_samples = 32'd10; I_decimate = 16'd1; I_4bit_mode = 1'b0; I_trigger = 1'b1;
    push_ev(EV_START, 18'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      I_data_valid = 1'b1;
      I_data_in    = 18'(100 + i);
      push_ev(EV_WR, 18'(100 + i));
      step();
    end
    check("third_write_present", {31'd0, O_wr}, 32'd1);
    reset = 1'b1;
    I_data_in = 18'h3ffff;
    step();
    check("reset_mid_capture_outputs", {9'd0, O_data, O_wr, O_capture_start, O_capture_done,
                                        O_armed, O_capturing}, 32'd0);
    reset = 1'b0; I_data_valid = 1'b0; I_trigger = 1'b0;
    repeat (4) step();
    check("reset_no_done", n_done - d0, 32'd0);
    check("reset_drained", exp_q.size(), 32'd0);
    arm(); d0 = n_done;
    capture(6, 0, 1'b1, 80, 1'b0, 0, -1, t);
    wait_done(d0);

    // Disable while armed
    arm();
    I_enabled = 1'b0;
    step();
    check("disabled_outputs", {9'd0, O_data, O_wr, O_capture_start, O_capture_done, O_armed,
                               O_capturing}, 32'd0);
    I_enabled = 1'b1;
    step();

    // Randomized captures
    for (int k = 0; k < 10; k++) begin
      arm(); d0 = n_done;
      capture(int'($urandom_range(1, 20)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              int'($urandom_range(40, 100)), 1'b0, 0, -1, t);
      wait_done(d0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
